sharpen_unit: RTL and testbench

SHARPEN_UNIT -- requirements
Module: sharpen_unit

---
 rtl/sharpen_unit.sv | 126 ++++++++++++
 tb/tb_sharpen_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sharpen_unit.sv
// sharpen_unit: accumulates a 3x3 window with a Laplacian-style sharpen kernel.
// The centre tap has weight +CENTER_W, the edge taps -1 and the corner taps 0.
// The sum is clamped to 0..255 and tagged with a DLX destination register index.
module sharpen_unit #(
    parameter int CENTER_W = 5  // unsigned centre-tap weight, legal 1..7
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [4:0] RD_IN,
    input  logic       PIX_VALID,
    input  logic [7:0] PIX,
    output logic       PIX_READY,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT,
    output logic [4:0] RD_OUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic [11:0] acc_q,    acc_d;     // two's-complement sum of weighted taps
    logic [7:0]  result_q, result_d;
    logic [4:0]  rd_q,     rd_d;

    logic        accept;
    logic [11:0] pix_ext;
    logic [11:0] term;
    logic [7:0]  clamped;

    assign accept  = (state_q == LOAD) && PIX_VALID;
    assign pix_ext = {4'b0000, PIX};

    // Weighted contribution of the pixel currently offered, by raster index.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        term = 12'd0;
        case (cnt_q)
            4'd4:                   term = pix_ext * 12'(CENTER_W);
            4'd1, 4'd3, 4'd5, 4'd7: term = 12'd0 - pix_ext;
            default:                term = 12'd0;
        endcase
    end

    // Saturate the signed accumulator into an unsigned 8-bit pixel.
    always_comb begin
        clamped = acc_q[7:0];
        if (acc_q[11]) begin
            clamped = 8'h00;
        end else if (|acc_q[10:8]) begin
            clamped = 8'hFF;
        end
    end

    // Next-state and datapath updates for the IDLE/LOAD/CALC/FIN sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    rd_d    = RD_IN;
                    acc_d   = 12'd0;
                    cnt_d   = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // START is deliberately not looked at here: BUSY is high.
                if (accept) begin
                    acc_d = acc_q + term;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd8) begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                result_d = clamped;
                state_d  = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            acc_q    <= 12'd0;
            result_q <= 8'd0;
            rd_q     <= 5'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    // Status strobes decode straight from the state register, so reset clears them at once.
    assign PIX_READY = (state_q == LOAD);
    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == FIN);
    assign RESULT    = result_q;
    assign RD_OUT    = rd_q;

endmodule

// File: tb/tb_sharpen_unit.sv
// tb_sharpen_unit: directed windows with hand-computed results; a scoreboard
// queue holds expected {RESULT, RD_OUT} pairs and a monitor checks each DONE.
module tb_sharpen_unit;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic [4:0] RD_IN;
    logic       PIX_VALID;
    logic [7:0] PIX;
    logic       PIX_READY;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic [4:0] RD_OUT;

    typedef struct packed {
        logic [7:0] result;
        logic [4:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   ops_expected = 0;

    sharpen_unit #(.CENTER_W(5)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .RD_IN    (RD_IN),
        .PIX_VALID(PIX_VALID),
        .PIX      (PIX),
        .PIX_READY(PIX_READY),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RESULT   (RESULT),
        .RD_OUT   (RD_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DONE must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (RST_N && DONE) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_result", 32'(RESULT), 32'(e.result));
                check("done_rd_out", 32'(RD_OUT), 32'(e.rd));
            end
        end
    end

    // Run one operation starting just after a falling edge.
    // gap_at: index before which PIX_VALID drops for 3 cycles (-1 = none).
    // stray_at: index whose cycle also carries START with RD_IN=12 (-1 = none).
    task automatic do_op(input logic [4:0] rd, input logic [7:0] w [9],
                         input int gap_at, input int stray_at, input logic [7:0] exp_res);
        exp_t e;
        START = 1'b1;
        RD_IN = rd;
        @(negedge CLK);
        START = 1'b0;
        RD_IN = 5'd0;
        check("busy_after_start", 32'(BUSY), 32'd1);
        check("ready_in_load", 32'(PIX_READY), 32'd1);
        check("rd_latched", 32'(RD_OUT), 32'(rd));
        for (int i = 0; i < 9; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < 3; g++) begin
                    PIX_VALID = 1'b0;
                    PIX = 8'hEE;
                    @(negedge CLK);
                    check("ready_during_gap", 32'(PIX_READY), 32'd1);
                    check("busy_during_gap", 32'(BUSY), 32'd1);
                end
            end
            PIX_VALID = 1'b1;
            PIX = w[i];
            if (i == stray_at) begin
                START = 1'b1;
                RD_IN = 5'd12;
            end
            if (i == 8) begin
                e.result = exp_res;
                e.rd = rd;
                sb_q.push_back(e);
                ops_expected++;
            end
            @(negedge CLK);
            START = 1'b0;
            RD_IN = 5'd0;
        end
        PIX_VALID = 1'b0;
        // One cycle after the accepting edge: CALC, no DONE yet.
        check("no_done_in_calc", 32'(DONE), 32'd0);
        check("ready_low_after_8", 32'(PIX_READY), 32'd0);
        if (stray_at >= 0) check("rd_after_stray_start", 32'(RD_OUT), 32'(rd));
        @(negedge CLK);
        // Two cycles after the accepting edge: DONE.
        check("done_latency", 32'(DONE), 32'd1);
        // A START sampled in FIN must be ignored.
        START = 1'b1;
        RD_IN = 5'd31;
        @(negedge CLK);
        START = 1'b0;
        RD_IN = 5'd0;
        check("done_one_cycle", 32'(DONE), 32'd0);
        check("idle_after_fin", 32'(BUSY), 32'd0);
        check("rd_held_after_fin_start", 32'(RD_OUT), 32'(rd));
        check("result_held", 32'(RESULT), 32'(exp_res));
    endtask

    logic [7:0] w_flat  [9];
    logic [7:0] w_high  [9];
    logic [7:0] w_low   [9];
    logic [7:0] w_ramp  [9];
    logic [7:0] w_mixed [9];

    initial begin
        w_flat  = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        w_high  = '{0, 50, 0, 50, 200, 50, 0, 50, 0};           // 1000-200 = 800 -> 255
        w_low   = '{255, 255, 255, 255, 0, 255, 255, 255, 255}; // -1020 -> 0
        w_ramp  = '{10, 20, 30, 40, 50, 60, 70, 80, 90};        // 250-200 = 50
        w_mixed = '{255, 10, 255, 10, 40, 10, 255, 10, 255};    // 200-40 = 160

        RST_N = 1'b0;
        START = 1'b0;
        RD_IN = 5'd0;
        PIX_VALID = 1'b0;
        PIX = 8'd0;
        repeat (3) @(negedge CLK);
        check("rst_result", 32'(RESULT), 32'd0);
        check("rst_rd_out", 32'(RD_OUT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_ready", 32'(PIX_READY), 32'd0);

        // Start on the very first edge after reset release.
        RST_N = 1'b1;
        do_op(5'd7, w_flat, -1, -1, 8'd100);

        // PIX_VALID in IDLE is ignored and outputs hold.
        PIX_VALID = 1'b1;
        PIX = 8'd0;
        repeat (2) @(negedge CLK);
        PIX_VALID = 1'b0;
        check("idle_pix_busy", 32'(BUSY), 32'd0);
        check("idle_pix_ready", 32'(PIX_READY), 32'd0);
        check("idle_pix_result", 32'(RESULT), 32'd100);
        check("idle_pix_rd", 32'(RD_OUT), 32'd7);

        do_op(5'd1, w_high, -1, -1, 8'd255);
        do_op(5'd2, w_low, -1, -1, 8'd0);
        do_op(5'd4, w_flat, 4, -1, 8'd100);
        do_op(5'd3, w_ramp, -1, 3, 8'd50);

        // Mid-load reset after 5 pixels: everything clears at once, no DONE.
        START = 1'b1;
        RD_IN = 5'd9;
        @(negedge CLK);
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            PIX_VALID = 1'b1;
            PIX = w_flat[i];
            @(negedge CLK);
        end
        PIX_VALID = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_ready", 32'(PIX_READY), 32'd0);
        check("midrst_done", 32'(DONE), 32'd0);
        check("midrst_result", 32'(RESULT), 32'd0);
        check("midrst_rd_out", 32'(RD_OUT), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("midrst_stays_idle", 32'(BUSY), 32'd0);

        do_op(5'd21, w_mixed, -1, -1, 8'd160);
        repeat (4) @(negedge CLK);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'(ops_expected));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
